// File: rtl/ddr2_arbiter_if.sv
// Signal bundle between ddr2_arbiter, its two cache clients and the DDR2 controller.
// slave is the arbiter's view; master is the view of the caches and controller.
interface ddr2_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) ();
    logic              c0_enable;
    logic              c0_read;
    logic [ADDR_W-1:0] c0_addr;
    logic [DATA_W-1:0] c0_wdata;
    logic              c0_available;
    logic [DATA_W-1:0] c0_rdata;

    logic              c1_enable;
    logic              c1_read;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_available;
    logic [DATA_W-1:0] c1_rdata;

    logic              mem_enable;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_available;
    logic [DATA_W-1:0] mem_rdata;

    logic              overflow;

    modport slave (
        input  c0_enable, c0_read, c0_addr, c0_wdata,
        output c0_available, c0_rdata,
        input  c1_enable, c1_read, c1_addr, c1_wdata,
        output c1_available, c1_rdata,
        output mem_enable, mem_read, mem_addr, mem_wdata,
        input  mem_available, mem_rdata,
        output overflow
    );

    modport master (
        output c0_enable, c0_read, c0_addr, c0_wdata,
        input  c0_available, c0_rdata,
        output c1_enable, c1_read, c1_addr, c1_wdata,
        input  c1_available, c1_rdata,
        input  mem_enable, mem_read, mem_addr, mem_wdata,
        output mem_available, mem_rdata,
        input  overflow
    );
endinterface

// File: rtl/ddr2_arbiter.sv
// Two-client DDR2 port arbiter: per-client command FIFOs, round-robin grant,
// one outstanding memory command, read data routed back to the requesting cache.
module ddr2_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128,
    parameter int QDEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    ddr2_arbiter_if.slave bus
);
    localparam int               PTR_W    = $clog2(QDEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef struct packed {
        logic              read;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // Per-client queue state
    cmd_t             in_cmd   [2];
    cmd_t             head     [2];
    logic [1:0]       enq_req;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       full;
    logic [1:0]       nonempty;

    cmd_t             q_mem_q  [2][QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [CNT_W-1:0] count_q  [2];
    logic             overflow_q;
    logic             overflow_d;

    // Arbiter / memory-side state
    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              mem_enable_q, mem_enable_d;
    cmd_t              mem_cmd_q, mem_cmd_d;
    logic [1:0]        avail_q, avail_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];

    assign enq_req   = {bus.c1_enable, bus.c0_enable};
    assign in_cmd[0] = '{read: bus.c0_read, addr: bus.c0_addr, wdata: bus.c0_wdata};
    assign in_cmd[1] = '{read: bus.c1_read, addr: bus.c1_addr, wdata: bus.c1_wdata};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c]     = (count_q[c] == FULL_CNT);
            nonempty[c] = (count_q[c] != '0);
            head[c]     = q_mem_q[c][rd_ptr_q[c]];
        end
    end

    // A pop in the same cycle frees the slot, so a full queue may still accept.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            push[c] = enq_req[c] && (!full[c] || pop[c]);
        end
    end

    assign overflow_d = overflow_q | (|(enq_req & ~push));

    // NOTE: queue storage has no reset; the counters and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                q_mem_q[c][wr_ptr_q[c]] <= in_cmd[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                end
                case ({push[c], pop[c]})
                    2'b10:   count_q[c] <= count_q[c] + 1'b1;
                    2'b01:   count_q[c] <= count_q[c] - 1'b1;
                    default: ;
                endcase
            end
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        // NOTE: every value this block drives gets a default first, so no path can infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_d       = last_q;
        pop          = '0;
        mem_enable_d = 1'b0;
        mem_cmd_d    = mem_cmd_q;
        avail_d      = '0;
        rdata_d      = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (|nonempty) begin
                    // With both pending, favour whoever was not served last.
                    grant_d = (&nonempty) ? ~last_q : nonempty[1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pop[grant_q] = 1'b1;
                mem_enable_d = 1'b1;
                mem_cmd_d    = head[grant_q];
                owner_d      = grant_q;
                state_d      = WAIT;
            end
            WAIT: begin
                if (bus.mem_available) begin
                    if (mem_cmd_q.read) begin
                        avail_d[owner_q] = 1'b1;
                        rdata_d[owner_q] = bus.mem_rdata;
                    end
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every process samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            mem_enable_q <= 1'b0;
            mem_cmd_q    <= '0;
            avail_q      <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            mem_enable_q <= mem_enable_d;
            mem_cmd_q    <= mem_cmd_d;
            avail_q      <= avail_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign bus.mem_enable   = mem_enable_q;
    assign bus.mem_read     = mem_cmd_q.read;
    assign bus.mem_addr     = mem_cmd_q.addr;
    assign bus.mem_wdata    = mem_cmd_q.wdata;
    assign bus.c0_available = avail_q[0];
    assign bus.c1_available = avail_q[1];
    assign bus.c0_rdata     = rdata_q[0];
    assign bus.c1_rdata     = rdata_q[1];
    assign bus.overflow     = overflow_q;
endmodule
